prn_line_sched: RTL and testbench

PRN_LINE_SCHED -- requirements
Module: prn_line_sched

---
 rtl/prn_line_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_prn_line_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prn_line_sched.sv
// prn_line_sched: print-line scheduler for a ping-pong line converter.
// A loader moves one line of words from the upstream FIFO into the converter's
// write bank. When a full line is waiting and the print bank is free, the banks
// are swapped. Each encoder fire then plays the preamble and the print readout
// of the swapped-in line. Loading of the next line overlaps printing.
module prn_line_sched #(
    parameter int WR_WORDS = 64,
    parameter int SP_WORDS = 8,
    parameter int RD_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        src_empty,
    output logic        src_rd_en,
    input  logic [15:0] src_data,
    output logic        cvt_wr_req,
    output logic [15:0] cvt_wr_data,
    output logic        cvt_data_switch,
    input  logic        fire_req,
    output logic        cvt_sp_start,
    output logic        cvt_sp_req,
    output logic        cvt_rd_req,
    input  logic        cvt_data_error,
    input  logic        err_clr,
    output logic        busy,
    output logic [15:0] lines_done,
    output logic        underrun,
    output logic        missed_fire,
    output logic        error
);

    // One phase counter serves both the preamble and the readout phases.
    localparam int PH_MAX = (SP_WORDS > RD_WORDS) ? SP_WORDS : RD_WORDS;
    localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int WCW    = (WR_WORDS > 1) ? $clog2(WR_WORDS) : 1;

    localparam logic [CW-1:0]  SP_LAST = CW'(SP_WORDS - 1);
    localparam logic [CW-1:0]  RD_LAST = CW'(RD_WORDS - 1);
    localparam logic [WCW-1:0] WR_LAST = WCW'(WR_WORDS - 1);

    // NOTE: an enum keeps state names visible in simulation and lets lint
    // catch assignments of values that are not legal states.
    typedef enum logic [2:0] {
        P_IDLE,
        P_SPS,
        P_SP,
        P_RD,
        P_DONE,
        P_ERR
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  ph_cnt, ph_cnt_nx;
    logic [WCW-1:0] wr_cnt;
    logic           wr_full;
    logic           rd_valid;
    logic           in_flight;
    logic           switch_go;

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------

    // Read the FIFO unless the line is full, the loader is halted, or the word
    // already in flight completes the line. Held off during reset so the
    // upstream FIFO is not drained while the block is being reset.
    assign src_rd_en = !rst && !wr_full && !src_empty && !error && !cvt_data_error
                       && !(in_flight && (wr_cnt == WR_LAST));

    // FIFO data arrives one cycle after the read strobe, so the write strobe is
    // simply the delayed read strobe and the data passes straight through.
    assign cvt_wr_req  = in_flight;
    assign cvt_wr_data = in_flight ? src_data : 16'h0000;

    // Swap banks only between prints; the printer must be idle and the print
    // bank already consumed.
    assign switch_go       = wr_full && !rd_valid && (state == P_IDLE) && enable && !error;
    assign cvt_data_switch = switch_go;

    // Loader bookkeeping: word count, full-line flag and print-bank-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
            wr_cnt    <= '0;
            wr_full   <= 1'b0;
            rd_valid  <= 1'b0;
        end else if (cvt_data_error) begin
            // Drop the word in flight; counts are cleared when the error is.
            in_flight <= 1'b0;
        end else if (state == P_ERR) begin
            in_flight <= 1'b0;
            if (err_clr) begin
                wr_cnt   <= '0;
                wr_full  <= 1'b0;
                rd_valid <= 1'b0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            in_flight <= src_rd_en;
            if (in_flight) begin
                if (wr_cnt == WR_LAST) begin
                    wr_cnt  <= '0;
                    wr_full <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (switch_go) begin
                wr_full  <= 1'b0;
                rd_valid <= 1'b1;
            end
            if (state == P_DONE) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Printer FSM
    // ------------------------------------------------------------------

    // Printer state and phase counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= P_IDLE;
            ph_cnt <= '0;
        end else begin
            state  <= state_nx;
            ph_cnt <= ph_cnt_nx;
        end
    end

    // Printer next-state and strobe decode; an error overrides any transition.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nx     = state;
        ph_cnt_nx    = ph_cnt;
        cvt_sp_start = 1'b0;
        cvt_sp_req   = 1'b0;
        cvt_rd_req   = 1'b0;

        case (state)
            P_IDLE: begin
                if (fire_req && rd_valid && enable) begin
                    state_nx = P_SPS;
                end
            end
            P_SPS: begin
                cvt_sp_start = 1'b1;
                ph_cnt_nx    = '0;
                state_nx     = P_SP;
            end
            P_SP: begin
                cvt_sp_req = 1'b1;
                if (ph_cnt == SP_LAST) begin
                    ph_cnt_nx = '0;
                    state_nx  = P_RD;
                end else begin
                    ph_cnt_nx = ph_cnt + 1'b1;
                end
            end
            P_RD: begin
                cvt_rd_req = 1'b1;
                if (ph_cnt == RD_LAST) begin
                    ph_cnt_nx = '0;
                    state_nx  = P_DONE;
                end else begin
                    ph_cnt_nx = ph_cnt + 1'b1;
                end
            end
            P_DONE: begin
                state_nx = P_IDLE;
            end
            P_ERR: begin
                if (err_clr) begin
                    state_nx = P_IDLE;
                end
            end
            default: begin
                state_nx = P_IDLE;
            end
        endcase

        if (cvt_data_error) begin
            state_nx  = P_ERR;
            ph_cnt_nx = '0;
        end
    end

    assign busy = (state != P_IDLE);

    // Status: line counter and the sticky underrun / missed-fire / error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lines_done  <= 16'h0000;
            underrun    <= 1'b0;
            missed_fire <= 1'b0;
            error       <= 1'b0;
        end else begin
            if (state == P_DONE) begin
                lines_done <= lines_done + 16'd1;
            end

            if (cvt_data_error) begin
                error <= 1'b1;
            end else if ((state == P_ERR) && err_clr) begin
                error <= 1'b0;
            end

            if (err_clr) begin
                underrun    <= 1'b0;
                missed_fire <= 1'b0;
            end else if (fire_req) begin
                if (state != P_IDLE) begin
                    missed_fire <= 1'b1;
                end else if (!rd_valid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prn_line_sched.sv
// tb_prn_line_sched: directed bench with a scoreboard. Stimulus pushes the
// expected converter writes and expected printer/switch strobes into queues; a
// monitor on the falling edge pops and compares whenever the DUT strobes.
module tb_prn_line_sched;

    localparam int WR_WORDS = 4;
    localparam int SP_WORDS = 2;
    localparam int RD_WORDS = 4;

    // Control strobe codes: {switch, sp_start, sp_req, rd_req}
    localparam logic [3:0] C_SW  = 4'b1000;
    localparam logic [3:0] C_SPS = 4'b0100;
    localparam logic [3:0] C_SP  = 4'b0010;
    localparam logic [3:0] C_RD  = 4'b0001;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        src_empty;
    logic        src_rd_en;
    logic [15:0] src_data;
    logic        cvt_wr_req;
    logic [15:0] cvt_wr_data;
    logic        cvt_data_switch;
    logic        fire_req;
    logic        cvt_sp_start;
    logic        cvt_sp_req;
    logic        cvt_rd_req;
    logic        cvt_data_error;
    logic        err_clr;
    logic        busy;
    logic [15:0] lines_done;
    logic        underrun;
    logic        missed_fire;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    logic [15:0] wr_q[$];
    logic [3:0]  ctrl_q[$];

    // Upstream FIFO model
    logic [15:0] fifo_mem [0:31];
    int          fifo_wp = 0;
    int          fifo_rp = 0;

    prn_line_sched #(
        .WR_WORDS(WR_WORDS),
        .SP_WORDS(SP_WORDS),
        .RD_WORDS(RD_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .src_empty      (src_empty),
        .src_rd_en      (src_rd_en),
        .src_data       (src_data),
        .cvt_wr_req     (cvt_wr_req),
        .cvt_wr_data    (cvt_wr_data),
        .cvt_data_switch(cvt_data_switch),
        .fire_req       (fire_req),
        .cvt_sp_start   (cvt_sp_start),
        .cvt_sp_req     (cvt_sp_req),
        .cvt_rd_req     (cvt_rd_req),
        .cvt_data_error (cvt_data_error),
        .err_clr        (err_clr),
        .busy           (busy),
        .lines_done     (lines_done),
        .underrun       (underrun),
        .missed_fire    (missed_fire),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign src_empty = (fifo_wp == fifo_rp);

    // FIFO read port: data shows up on src_data the cycle after the strobe.
    initial src_data = 16'h0000;
    always @(posedge clk) begin
        if (src_rd_en && !src_empty) begin
            src_data <= fifo_mem[fifo_rp[4:0]];
            fifo_rp  <= fifo_rp + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [15:0] d);
        fifo_mem[fifo_wp[4:0]] = d;
        fifo_wp++;
    endtask

    task automatic expect_wr(input logic [15:0] d);
        wr_q.push_back(d);
    endtask

    task automatic expect_ctrl(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) ctrl_q.push_back(c);
    endtask

    task automatic expect_print(input int n_rd);
        expect_ctrl(C_SPS, 1);
        expect_ctrl(C_SP, SP_WORDS);
        expect_ctrl(C_RD, n_rd);
    endtask

    task automatic pulse_fire();
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
    endtask

    // Monitor: compare every strobe the DUT presents against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0]  ctrl;
            logic [15:0] exp_d;
            logic [3:0]  exp_c;
            if (cvt_wr_req === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", {16'h0, cvt_wr_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_d = wr_q.pop_front();
                    check("wr_data", {16'h0, cvt_wr_data}, {16'h0, exp_d});
                end
            end
            ctrl = {cvt_data_switch, cvt_sp_start, cvt_sp_req, cvt_rd_req};
            if (ctrl != 4'b0000) begin
                if (ctrl_q.size() == 0) begin
                    check("ctrl_unexpected", {28'h0, ctrl}, 32'h0);
                end else begin
                    exp_c = ctrl_q.pop_front();
                    check("ctrl_strobe", {28'h0, ctrl}, {28'h0, exp_c});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        fire_req       = 1'b0;
        cvt_data_error = 1'b0;
        err_clr        = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_lines_done", lines_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_missed_fire", missed_fire, 0);
        check("rst_error", error, 0);
        check("rst_strobes", {cvt_wr_req, cvt_data_switch, cvt_sp_start, cvt_sp_req, cvt_rd_req}, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Load one line, then expect a single bank switch
        for (int i = 0; i < WR_WORDS; i++) begin
            fifo_push(16'((i + 1) * 16'h1111));
            expect_wr(16'((i + 1) * 16'h1111));
        end
        expect_ctrl(C_SW, 1);
        repeat (10) tick();
        check("t1_wr_drained", wr_q.size(), 0);
        check("t1_ctrl_drained", ctrl_q.size(), 0);
        check("t1_busy", busy, 0);

        // Print the line and check latency of first and last strobes
        expect_print(RD_WORDS);
        pulse_fire();
        check("t2_sp_start_latency", cvt_sp_start, 1);
        repeat (SP_WORDS + RD_WORDS) tick();
        check("t2_last_rd_latency", cvt_rd_req, 1);
        tick();
        check("t2_rd_stops", cvt_rd_req, 0);
        check("t2_busy_in_done", busy, 1);
        tick();
        check("t2_busy_after", busy, 0);
        check("t2_lines_done", lines_done, 1);

        // Fire with nothing loaded
        pulse_fire();
        check("t3_underrun_set", underrun, 1);
        check("t3_busy", busy, 0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_underrun_clr", underrun, 0);

        // Load line A; then load line B while A prints, with a stray fire mid-readout
        for (int i = 0; i < WR_WORDS; i++) begin
            fifo_push(16'hA001 + 16'(i));
            expect_wr(16'hA001 + 16'(i));
        end
        expect_ctrl(C_SW, 1);
        repeat (10) tick();
        for (int i = 0; i < WR_WORDS; i++) begin
            fifo_push(16'hB001 + 16'(i));
            expect_wr(16'hB001 + 16'(i));
        end
        expect_print(RD_WORDS);
        expect_ctrl(C_SW, 1);
        pulse_fire();
        repeat (4) tick();
        check("t4_in_rd", cvt_rd_req, 1);
        pulse_fire();
        check("t4_missed_fire", missed_fire, 1);
        repeat (10) tick();
        check("t4_lines_done", lines_done, 2);
        check("t4_busy", busy, 0);
        check("t4_wr_drained", wr_q.size(), 0);
        check("t4_ctrl_drained", ctrl_q.size(), 0);

        // Converter error during the preamble
        expect_ctrl(C_SPS, 1);
        expect_ctrl(C_SP, 1);
        pulse_fire();
        tick();
        cvt_data_error = 1'b1;
        tick();
        cvt_data_error = 1'b0;
        check("t5_error_set", error, 1);
        check("t5_busy", busy, 1);
        check("t5_strobes_off", {cvt_wr_req, cvt_data_switch, cvt_sp_start, cvt_sp_req, cvt_rd_req}, 0);
        for (int i = 0; i < WR_WORDS; i++) fifo_push(16'hC001 + 16'(i));
        repeat (5) tick();
        check("t5_error_held", error, 1);
        check("t5_loader_halted", fifo_rp, fifo_wp - WR_WORDS);
        check("t5_lines_kept", lines_done, 2);
        for (int i = 0; i < WR_WORDS; i++) expect_wr(16'hC001 + 16'(i));
        expect_ctrl(C_SW, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_error_clr", error, 0);
        check("t5_missed_clr", missed_fire, 0);
        check("t5_idle", busy, 0);
        repeat (10) tick();
        check("t5_ctrl_drained", ctrl_q.size(), 0);

        // Reset on the third readout cycle
        expect_print(3);
        pulse_fire();
        repeat (SP_WORDS + 3) tick();
        check("t6_third_rd", cvt_rd_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_strobes_off", {cvt_wr_req, cvt_data_switch, cvt_sp_start, cvt_sp_req, cvt_rd_req}, 0);
        check("t6_lines_done", lines_done, 0);
        check("t6_busy", busy, 0);
        check("t6_flags", {underrun, missed_fire, error}, 0);
        repeat (3) tick();
        check("t6_wr_drained", wr_q.size(), 0);
        check("t6_ctrl_drained", ctrl_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
